// File: rtl/audio_ram_player.sv
`default_nettype none
// ============================================================================
// Module   : audio_ram_player
// Purpose  : Streams packed stereo PCM words from sample RAM through a
//            prefetch FIFO to independent left/right 16-bit streams.
// Options  : AUDIO_PLAYER_UNDERRUN_CNT_EN adds the o_underrun_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module audio_ram_player #(
    parameter int ADDR_W     = 18,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop,
    input  logic [15:0]       i_base_word,
    input  logic [15:0]       i_num_words,
    output logic [ADDR_W-1:0] o_avm_address,
    output logic              o_avm_read,
    input  logic              i_avm_waitrequest,
    input  logic [31:0]       i_avm_readdata,
    input  logic              i_avm_readdatavalid,
    output logic [15:0]       o_left_data,
    output logic              o_left_valid,
    input  logic              i_left_ready,
    output logic [15:0]       o_right_data,
    output logic              o_right_valid,
    input  logic              i_right_ready,
    output logic              o_busy,
`ifdef AUDIO_PLAYER_UNDERRUN_CNT_EN
    output logic [15:0]       o_underrun_cnt,
`endif
    output logic              o_done
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_loop;
    logic [15:0]         r_base;
    logic [15:0]         r_num;
    logic [15:0]         r_idx;

    logic                r_avm_read;
    logic [ADDR_W-1:0]   r_avm_address;
    logic                r_outstanding;

    logic [31:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic [15:0]         r_left_data;
    logic [15:0]         r_right_data;
    logic                r_left_valid;
    logic                r_right_valid;
    logic                r_done;

    logic                w_active;
    logic                w_flush;
    logic                w_issue;
    logic                w_done_nxt;
    logic                w_last;
    logic                w_can_issue;
    logic                w_quiet;
    logic                w_fifo_empty;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_lv_rem;
    logic                w_rv_rem;
    logic [15:0]         w_word;

    assign w_active     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_flush      = (r_state == ST_FLUSH) || (w_active && i_stop);
    assign w_fifo_empty = (r_count == '0);
    assign w_last       = (r_idx == (r_num - 16'd1));
    assign w_quiet      = !r_avm_read && !r_outstanding;
    assign w_can_issue  = w_quiet && (r_count < c_DEPTH);
    assign w_accept     = r_avm_read && !i_avm_waitrequest;
    // The first request is issued straight from the start inputs.
    assign w_word       = (r_state == ST_IDLE) ? i_base_word : (r_base + r_idx);

    // Channel flags that survive this cycle's handshakes.
    assign w_lv_rem = r_left_valid  && !i_left_ready;
    assign w_rv_rem = r_right_valid && !i_right_ready;

    assign w_push = i_avm_readdatavalid && r_outstanding && w_active && !w_flush;
    assign w_pop  = w_active && !w_flush && !w_lv_rem && !w_rv_rem && !w_fifo_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_num_words == 16'd0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_issue     = 1'b1;
                        w_state_nxt = ((i_num_words == 16'd1) && !i_loop) ? ST_DRAIN : ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (i_stop) begin
                    w_state_nxt = ST_FLUSH;
                end else if (w_can_issue) begin
                    w_issue = 1'b1;
                    if (w_last && !r_loop) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (i_stop) begin
                    w_state_nxt = ST_FLUSH;
                end else if (w_quiet && w_fifo_empty && !r_left_valid && !r_right_valid) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (w_quiet) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Window parameters and the index of the next word to request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_loop <= 1'b0;
            r_base <= 16'd0;
            r_num  <= 16'd0;
            r_idx  <= 16'd0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_loop <= i_loop;
            r_base <= i_base_word;
            r_num  <= i_num_words;
            r_idx  <= (i_num_words == 16'd1) ? 16'd0 : 16'd1;
        end else if (w_issue) begin
            r_idx  <= w_last ? 16'd0 : (r_idx + 16'd1);
        end
    end

    // A request already presented is held until accepted, even after stop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_avm_read    <= 1'b0;
            r_avm_address <= '0;
            r_outstanding <= 1'b0;
        end else begin
            if (w_issue) begin
                r_avm_read    <= 1'b1;
                r_avm_address <= ADDR_W'({w_word, 2'b00});
            end else if (w_accept) begin
                r_avm_read    <= 1'b0;
            end
            if (w_accept) begin
                r_outstanding <= 1'b1;
            end else if (i_avm_readdatavalid) begin
                r_outstanding <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_avm_readdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output stage: the next word loads in the cycle its predecessor finishes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_left_data   <= 16'd0;
            r_right_data  <= 16'd0;
            r_left_valid  <= 1'b0;
            r_right_valid <= 1'b0;
        end else if (w_flush) begin
            r_left_valid  <= 1'b0;
            r_right_valid <= 1'b0;
        end else if (w_pop) begin
            r_left_data   <= r_mem[r_rd_ptr][31:16];
            r_right_data  <= r_mem[r_rd_ptr][15:0];
            r_left_valid  <= 1'b1;
            r_right_valid <= 1'b1;
        end else begin
            r_left_valid  <= w_lv_rem;
            r_right_valid <= w_rv_rem;
        end
    end

`ifdef AUDIO_PLAYER_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_underrun_cnt <= 16'd0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_underrun_cnt <= 16'd0;
        end else if ((r_state == ST_RUN) && w_fifo_empty && w_quiet &&
                     !r_left_valid && !r_right_valid && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign o_underrun_cnt = r_underrun_cnt;
`else
    // Underrun accounting is not built in this configuration.
`endif

    assign o_avm_address = r_avm_address;
    assign o_avm_read    = r_avm_read;
    assign o_left_data   = r_left_data;
    assign o_right_data  = r_right_data;
    assign o_left_valid  = r_left_valid;
    assign o_right_valid = r_right_valid;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = r_done;

endmodule
`default_nettype wire
